// File: rtl/lc3b_mem_arbiter_pkg.sv
// Shared LC-3b types used by the memory arbiter slice: word, byte-lane mask
// and the arbiter FSM state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_be;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } lc3b_arb_state;

  localparam lc3b_mem_be BE_ALL = 2'b11;

endpackage

// File: rtl/lc3b_mem_arbiter_if.sv
// Bundles the fetch port, data port and physical memory port of the arbiter.
// master = arbiter view, slave = requesters/memory view.
interface lc3b_mem_arbiter_if;
  import lc3b_types::*;

  logic       i_read;
  lc3b_word   i_address;
  lc3b_word   i_rdata;
  logic       i_resp;

  logic       d_read;
  logic       d_write;
  lc3b_mem_be d_byte_enable;
  lc3b_word   d_address;
  lc3b_word   d_wdata;
  lc3b_word   d_rdata;
  logic       d_resp;

  logic       pmem_read;
  logic       pmem_write;
  lc3b_mem_be pmem_byte_enable;
  lc3b_word   pmem_address;
  lc3b_word   pmem_wdata;
  lc3b_word   pmem_rdata;
  logic       pmem_resp;

  logic       busy;

  modport master (
    input  i_read, i_address, d_read, d_write, d_byte_enable, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write,
           pmem_byte_enable, pmem_address, pmem_wdata, busy
  );

  modport slave (
    output i_read, i_address, d_read, d_write, d_byte_enable, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write,
           pmem_byte_enable, pmem_address, pmem_wdata, busy
  );

endinterface

// File: rtl/lc3b_mem_arbiter_burst_guard.sv
// Starvation guard: counts consecutive data grants taken while a fetch waits
// and forces the next grant to fetch once the count reaches DATA_BURST_MAX.
module lc3b_arb_burst_guard #(
  parameter int DATA_BURST_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic i_read,
  input  logic grant_d,
  input  logic grant_i,
  output logic force_fetch
);

  localparam int CNT_W = (DATA_BURST_MAX > 0) ? $clog2(DATA_BURST_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_BURST_MAX);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (grant_i || (idle && !i_read)) begin
      cnt <= '0;
    end else if (grant_d && i_read && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A zero limit disables the guard entirely: data always wins.
  assign force_fetch = (DATA_BURST_MAX != 0) && i_read && (cnt == CNT_MAX);

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// Shares the single physical memory port between instruction fetch and the
// MEM-stage data access; data has priority, fetch is protected from starvation.
module lc3b_mem_arbiter
  import lc3b_types::*;
#(
  parameter int DATA_BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lc3b_mem_arbiter_if.master    bus
);

  lc3b_arb_state state, state_next;

  logic       d_req;
  logic       force_fetch;
  logic       grant_d;
  logic       grant_i;

  logic       lat_sel_d;
  logic       lat_write;
  lc3b_word   lat_addr;
  lc3b_word   lat_wdata;
  lc3b_mem_be lat_be;
  logic       cancel;
  lc3b_word   i_rdata_q;
  lc3b_word   d_rdata_q;

  // A simultaneous read+write is treated as a write; the read is dropped.
  assign d_req   = bus.d_read | bus.d_write;
  assign grant_d = (state == IDLE) && d_req && !force_fetch;
  assign grant_i = (state == IDLE) && bus.i_read && (!d_req || force_fetch);

  lc3b_arb_burst_guard #(
    .DATA_BURST_MAX (DATA_BURST_MAX)
  ) u_burst_guard (
    .clk         (clk),
    .rst_n       (rst_n),
    .idle        (state == IDLE),
    .i_read      (bus.i_read),
    .grant_d     (grant_d),
    .grant_i     (grant_i),
    .force_fetch (force_fetch)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_next = SERVE_D;
        else if (grant_i) state_next = SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (bus.pmem_resp) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command fields are frozen at grant so requester changes mid-transaction
  // never reach the memory port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_sel_d <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      cancel    <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (grant_d) begin
        lat_sel_d <= 1'b1;
        lat_write <= bus.d_write;
        lat_addr  <= bus.d_address;
        lat_wdata <= bus.d_wdata;
        lat_be    <= bus.d_write ? bus.d_byte_enable : BE_ALL;
      end else if (grant_i) begin
        lat_sel_d <= 1'b0;
        lat_write <= 1'b0;
        lat_addr  <= bus.i_address;
        lat_be    <= BE_ALL;
      end

      if ((state == SERVE_I && !bus.i_read) || (state == SERVE_D && !d_req)) begin
        cancel <= 1'b1;
      end else if (state == DONE) begin
        cancel <= 1'b0;
      end

      if (state == SERVE_I && bus.pmem_resp) i_rdata_q <= bus.pmem_rdata;
      if (state == SERVE_D && bus.pmem_resp) d_rdata_q <= bus.pmem_rdata;
    end
  end

  always_comb begin
    bus.pmem_read        = (state == SERVE_I) || ((state == SERVE_D) && !lat_write);
    bus.pmem_write       = (state == SERVE_D) && lat_write;
    bus.pmem_address     = lat_addr;
    bus.pmem_wdata       = lat_wdata;
    bus.pmem_byte_enable = lat_be;
    bus.i_resp           = (state == DONE) && !lat_sel_d && !cancel;
    bus.d_resp           = (state == DONE) &&  lat_sel_d && !cancel;
    bus.i_rdata          = i_rdata_q;
    bus.d_rdata          = d_rdata_q;
    bus.busy             = (state != IDLE);
  end

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Directed bench for lc3b_mem_arbiter: one instance with a burst limit of 2 and
// one with strict data priority, both fed the same stimulus.
module tb_lc3b_mem_arbiter;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  lc3b_mem_arbiter_if bus ();
  lc3b_mem_arbiter_if bus0 ();

  lc3b_mem_arbiter #(.DATA_BURST_MAX(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  lc3b_mem_arbiter #(.DATA_BURST_MAX(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  assign bus0.i_read        = bus.i_read;
  assign bus0.i_address     = bus.i_address;
  assign bus0.d_read        = bus.d_read;
  assign bus0.d_write       = bus.d_write;
  assign bus0.d_byte_enable = bus.d_byte_enable;
  assign bus0.d_address     = bus.d_address;
  assign bus0.d_wdata       = bus.d_wdata;
  assign bus0.pmem_rdata    = bus.pmem_rdata;
  assign bus0.pmem_resp     = bus.pmem_resp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    bus.i_read = 0; bus.i_address = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_byte_enable = '0;
    bus.d_address = '0; bus.d_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 0;
    rst_n = 0;
    repeat (2) cyc();

    chk("rst_busy", bus.busy, 0);
    chk("rst_pmem_read", bus.pmem_read, 0);
    chk("rst_pmem_write", bus.pmem_write, 0);
    chk("rst_pmem_addr", bus.pmem_address, 0);
    chk("rst_pmem_be", bus.pmem_byte_enable, 0);
    chk("rst_i_resp", bus.i_resp, 0);
    chk("rst_d_resp", bus.d_resp, 0);
    chk("rst_i_rdata", bus.i_rdata, 0);

    // Single fetch: request at cycle 0, pmem_resp at cycle 3, i_resp at cycle 4.
    rst_n = 1; bus.i_read = 1; bus.i_address = 16'h3000;
    cyc();
    chk("f_pmem_read_c1", bus.pmem_read, 1);
    chk("f_pmem_addr", bus.pmem_address, 16'h3000);
    chk("f_busy", bus.busy, 1);
    cyc();
    chk("f_pmem_read_c2", bus.pmem_read, 1);
    cyc();
    chk("f_pmem_read_c3", bus.pmem_read, 1);
    chk("f_i_resp_early", bus.i_resp, 0);
    bus.pmem_resp = 1; bus.pmem_rdata = 16'h1234;
    cyc();
    bus.pmem_resp = 0;
    chk("f_i_resp", bus.i_resp, 1);
    chk("f_i_rdata", bus.i_rdata, 16'h1234);
    chk("f_pmem_read_dropped", bus.pmem_read, 0);
    chk("f_d_resp", bus.d_resp, 0);
    bus.i_read = 0;
    cyc();
    chk("f_i_resp_single", bus.i_resp, 0);
    chk("f_idle", bus.busy, 0);

    // Simultaneous fetch and data write: data first, fetch after DONE+IDLE.
    bus.i_read = 1; bus.i_address = 16'h3002;
    bus.d_write = 1; bus.d_address = 16'h4000; bus.d_wdata = 16'hBEEF; bus.d_byte_enable = 2'b01;
    cyc();
    chk("s_pmem_write", bus.pmem_write, 1);
    chk("s_pmem_read", bus.pmem_read, 0);
    chk("s_pmem_be", bus.pmem_byte_enable, 2'b01);
    chk("s_pmem_addr", bus.pmem_address, 16'h4000);
    chk("s_pmem_wdata", bus.pmem_wdata, 16'hBEEF);
    bus.pmem_resp = 1;
    cyc();
    bus.pmem_resp = 0;
    chk("s_d_resp", bus.d_resp, 1);
    chk("s_i_resp", bus.i_resp, 0);
    bus.d_write = 0;
    cyc();
    chk("s_gap_idle", bus.busy, 0);
    cyc();
    chk("s_fetch_read", bus.pmem_read, 1);
    chk("s_fetch_addr", bus.pmem_address, 16'h3002);
    chk("s_fetch_be", bus.pmem_byte_enable, 2'b11);
    bus.pmem_resp = 1; bus.pmem_rdata = 16'hABCD;
    cyc();
    bus.pmem_resp = 0;
    chk("s_fetch_resp", bus.i_resp, 1);
    chk("s_fetch_rdata", bus.i_rdata, 16'hABCD);
    bus.i_read = 0;
    cyc();

    // Fetch cancelled by a branch flush while in SERVE_I.
    bus.i_read = 1; bus.i_address = 16'h3004;
    cyc();
    chk("c_pmem_read", bus.pmem_read, 1);
    bus.i_read = 0;
    cyc();
    chk("c_pmem_read_held", bus.pmem_read, 1);
    bus.pmem_resp = 1; bus.pmem_rdata = 16'h5A5A;
    cyc();
    bus.pmem_resp = 0;
    chk("c_i_resp_suppressed", bus.i_resp, 0);
    chk("c_i_rdata", bus.i_rdata, 16'h5A5A);
    chk("c_pmem_read_dropped", bus.pmem_read, 0);
    cyc();
    chk("c_busy_clear", bus.busy, 0);
    chk("c_i_resp_none", bus.i_resp, 0);

    // Reset during SERVE_D, then a late pmem_resp.
    bus.d_read = 1; bus.d_address = 16'h6000;
    cyc();
    chk("r_pmem_read", bus.pmem_read, 1);
    rst_n = 0;
    cyc();
    chk("r_pmem_read_low", bus.pmem_read, 0);
    chk("r_busy_low", bus.busy, 0);
    chk("r_pmem_addr", bus.pmem_address, 0);
    chk("r_i_rdata", bus.i_rdata, 0);
    rst_n = 1; bus.d_read = 0; bus.pmem_resp = 1;
    cyc();
    bus.pmem_resp = 0;
    chk("r_late_d_resp", bus.d_resp, 0);
    chk("r_late_busy", bus.busy, 0);
    cyc();
    chk("r_late_d_resp2", bus.d_resp, 0);
    chk("r_late_i_resp2", bus.i_resp, 0);

    // Conflicting data command resolves to a write.
    bus.d_read = 1; bus.d_write = 1; bus.d_address = 16'h7000;
    bus.d_wdata = 16'h1111; bus.d_byte_enable = 2'b10;
    cyc();
    chk("x_pmem_write", bus.pmem_write, 1);
    chk("x_pmem_read", bus.pmem_read, 0);
    chk("x_pmem_be", bus.pmem_byte_enable, 2'b10);
    bus.pmem_resp = 1;
    cyc();
    bus.pmem_resp = 0;
    chk("x_d_resp", bus.d_resp, 1);
    bus.d_read = 0; bus.d_write = 0;
    cyc();
    chk("x_d_resp_single", bus.d_resp, 0);

    // Starvation guard: limit 2 yields D,D,I,D,D,I; limit 0 never grants fetch.
    rst_n = 0;
    cyc();
    rst_n = 1;
    bus.i_read = 1; bus.i_address = 16'h3000;
    bus.d_read = 1; bus.d_address = 16'h5000;
    for (int k = 0; k < 6; k++) begin
      logic [15:0] exp_addr;
      exp_addr = (k == 2 || k == 5) ? 16'h3000 : 16'h5000;
      cyc();
      chk($sformatf("g2_grant%0d", k), dut.bus.pmem_address, exp_addr);
      chk($sformatf("g2_read%0d", k), bus.pmem_read, 1);
      chk($sformatf("g0_grant%0d", k), bus0.pmem_address, 16'h5000);
      bus.pmem_resp = 1;
      cyc();
      bus.pmem_resp = 0;
      cyc();
    end
    bus.i_read = 0; bus.d_read = 0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
